// File: rtl/dep_pipe_tracker.sv
// dep_pipe_tracker: tracks destination-register state of the AG/ME/EX stages
// and steers advance / hold / bubble / flush for the decode dependency check.
module dep_pipe_tracker (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       D_V,
  input  logic [2:0] D_DRID1,
  input  logic [2:0] D_DRID2,
  input  logic       D_LD_GPR1,
  input  logic       D_LD_GPR2,
  input  logic       D_LD_SEG,
  input  logic       D_LD_CSEG,
  input  logic       D_LD_MM,
  input  logic       DEP_STALL,
  input  logic       ME_STALL,
  input  logic       FLUSH,
  output logic [2:0] AG_DRID1,
  output logic [2:0] AG_DRID2,
  output logic [2:0] ME_DRID1,
  output logic [2:0] ME_DRID2,
  output logic [2:0] EX_DRID1,
  output logic [2:0] EX_DRID2,
  output logic       V_AG_LD_GPR1,
  output logic       V_AG_LD_GPR2,
  output logic       V_AG_LD_SEG,
  output logic       V_AG_LD_CSEG,
  output logic       V_AG_LD_MM,
  output logic       V_ME_LD_GPR1,
  output logic       V_ME_LD_GPR2,
  output logic       V_ME_LD_SEG,
  output logic       V_ME_LD_CSEG,
  output logic       V_ME_LD_MM,
  output logic       V_EX_LD_GPR1,
  output logic       V_EX_LD_GPR2,
  output logic       V_EX_LD_SEG,
  output logic       V_EX_LD_CSEG,
  output logic       V_EX_LD_MM,
  output logic       D_LD_EN,
  output logic       AG_BUBBLE,
  output logic [1:0] PIPE_STATE,
  output logic [15:0] STALL_CNT,
  output logic       DEP_ERR
);

  localparam int unsigned RID_W  = 3;
  localparam int unsigned LD_W   = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CSC_W  = 3;
  localparam logic [CSC_W-1:0] CSC_MAX  = CSC_W'(4);
  localparam logic [CSC_W-1:0] CSC_TRIP = CSC_W'(3);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Per-stage payload; vld holds load bits already qualified by stage valid,
  // ordered {mm, cseg, seg, gpr2, gpr1}.
  typedef struct packed {
    logic [RID_W-1:0] drid1;
    logic [RID_W-1:0] drid2;
    logic [LD_W-1:0]  vld;
  } stage_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DEPW = 2'd1,
    ST_MEMW = 2'd2
  } pipe_state_e;

  stage_t           ag_q, me_q, ex_q;
  stage_t           ag_d, me_d, ex_d;
  stage_t           dec_stage;
  logic             bubble_q, bubble_d;
  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CSC_W-1:0] csc_q, csc_d;
  logic             err_q, err_d;

  // Decode-stage fields packaged as a candidate AG entry.
  always_comb begin
    dec_stage       = '0;
    dec_stage.drid1 = D_DRID1;
    dec_stage.drid2 = D_DRID2;
    dec_stage.vld   = D_V ? {D_LD_MM, D_LD_CSEG, D_LD_SEG, D_LD_GPR2, D_LD_GPR1}
                          : LD_W'(0);
  end

  // Decode latch enable: flush always reopens decode, otherwise any stall closes it.
  assign D_LD_EN = FLUSH | (~ME_STALL & ~DEP_STALL);

  // Next-state selection with priority flush > memory stall > dependency stall > advance.
  always_comb begin
    ag_d     = ag_q;
    me_d     = me_q;
    ex_d     = ex_q;
    bubble_d = bubble_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    csc_d    = csc_q;
    err_d    = err_q;

    if (FLUSH) begin
      ag_d.vld = '0;
      me_d.vld = '0;
      ex_d.vld = '0;
      bubble_d = 1'b0;
      state_d  = ST_RUN;
      csc_d    = '0;
    end else if (ME_STALL) begin
      // AG and ME hold; the EX slot drains to invalid.
      ex_d     = me_q;
      ex_d.vld = '0;
      state_d  = ST_MEMW;
    end else if (DEP_STALL) begin
      // Inject a bubble into AG while older entries keep moving.
      ag_d     = dec_stage;
      ag_d.vld = '0;
      me_d     = ag_q;
      ex_d     = me_q;
      bubble_d = 1'b1;
      state_d  = ST_DEPW;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (csc_q >= CSC_TRIP) begin
        err_d = 1'b1;
      end
      if (csc_q != CSC_MAX) begin
        csc_d = csc_q + CSC_W'(1);
      end
    end else begin
      ag_d     = dec_stage;
      me_d     = ag_q;
      ex_d     = me_q;
      bubble_d = 1'b0;
      state_d  = ST_RUN;
      csc_d    = '0;
    end
  end

  // Pipeline tracking and control state registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ag_q     <= '0;
      me_q     <= '0;
      ex_q     <= '0;
      bubble_q <= 1'b0;
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      csc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ag_q     <= ag_d;
      me_q     <= me_d;
      ex_q     <= ex_d;
      bubble_q <= bubble_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csc_q    <= csc_d;
      err_q    <= err_d;
    end
  end

  // Output mapping straight from the registers.
  assign AG_DRID1 = ag_q.drid1;
  assign AG_DRID2 = ag_q.drid2;
  assign ME_DRID1 = me_q.drid1;
  assign ME_DRID2 = me_q.drid2;
  assign EX_DRID1 = ex_q.drid1;
  assign EX_DRID2 = ex_q.drid2;

  assign {V_AG_LD_MM, V_AG_LD_CSEG, V_AG_LD_SEG, V_AG_LD_GPR2, V_AG_LD_GPR1} = ag_q.vld;
  assign {V_ME_LD_MM, V_ME_LD_CSEG, V_ME_LD_SEG, V_ME_LD_GPR2, V_ME_LD_GPR1} = me_q.vld;
  assign {V_EX_LD_MM, V_EX_LD_CSEG, V_EX_LD_SEG, V_EX_LD_GPR2, V_EX_LD_GPR1} = ex_q.vld;

  assign AG_BUBBLE  = bubble_q;
  assign PIPE_STATE = state_q;
  assign STALL_CNT  = cnt_q;
  assign DEP_ERR    = err_q;

endmodule
